// File: rtl/rv32imf_mem_responder.sv
`default_nettype none
// ============================================================================
// rv32imf_mem_responder : memory-side req/gnt/rvalid responder with byte-lane
// RAM, programmable grant wait states, fixed read latency, tohost/putchar MMIO.
// Rev 1.0
// ============================================================================
module rv32imf_mem_responder #(
  parameter int          MEM_AW       = 14,
  parameter int          RD_LATENCY   = 1,
  parameter int          GNT_WAIT     = 0,
  parameter logic [31:0] TOHOST_ADDR  = 32'h0000_1000,
  parameter logic [31:0] PUTCHAR_ADDR = 32'h0000_1004
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        putchar_valid_o,
  output logic [7:0]  putchar_data_o,
  output logic        exit_valid_o,
  output logic [31:0] exit_code_o
);

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;

  logic [31:0] mem [0:(2**MEM_AW)-1];

  logic [31:0]       addr_word;
  logic [MEM_AW-1:0] widx;
  logic              is_tohost;
  logic              is_putchar;
  logic              accept;
  logic              tohost_wr;
  logic              putchar_wr;
  logic              mem_wr;
  logic [31:0]       rd_word;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^addr_i[1:0];

  assign addr_word  = {addr_i[31:2], 2'b00};
  assign widx       = addr_i[MEM_AW+1:2];
  assign is_tohost  = (addr_word == TOHOST_ADDR);
  assign is_putchar = (addr_word == PUTCHAR_ADDR);

  assign accept     = req_i && gnt_o;
  // Only a full-word tohost write is the exit register; partial writes fall through to RAM.
  assign tohost_wr  = accept && we_i && is_tohost && (be_i == 4'hF);
  assign putchar_wr = accept && we_i && is_putchar;
  assign mem_wr     = accept && we_i && !tohost_wr && !putchar_wr;
  assign rd_word    = (accept && !we_i && !is_tohost && !is_putchar) ? mem[widx] : 32'h0;

  generate
    if (GNT_WAIT == 0) begin : g_nowait
      assign gnt_o = req_i && !rst_i;
    end else begin : g_wait
      localparam logic [2:0] WAIT_N = 3'(GNT_WAIT);

      state_t     state_q, state_d;
      logic [2:0] wcnt_q, wcnt_d;
      logic       gnt;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          state_q <= IDLE;
          wcnt_q  <= 3'd0;
        end else begin
          state_q <= state_d;
          wcnt_q  <= wcnt_d;
        end
      end

      always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        gnt     = 1'b0;
        case (state_q)
          IDLE: begin
            if (req_i) begin
              state_d = WAIT;
              wcnt_d  = 3'd1;
            end
          end
          WAIT: begin
            if (!req_i) begin
              state_d = IDLE;
              wcnt_d  = 3'd0;
            end else if (wcnt_q == WAIT_N) begin
              gnt     = 1'b1;
              state_d = IDLE;
              wcnt_d  = 3'd0;
            end else begin
              wcnt_d  = wcnt_q + 3'd1;
            end
          end
          default: begin
            state_d = IDLE;
            wcnt_d  = 3'd0;
          end
        endcase
      end

      assign gnt_o = gnt && !rst_i;
    end
  endgenerate

  // Fixed-latency response pipe; non-read slots carry zero so rdata_o idles at 0.
  logic [RD_LATENCY-1:0] vld_q;
  logic [31:0]           data_q [RD_LATENCY];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) data_q[i] <= 32'h0;
    end else begin
      vld_q[0]  <= accept;
      data_q[0] <= rd_word;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_q[i]  <= vld_q[i-1];
        data_q[i] <= data_q[i-1];
      end
    end
  end

  assign rvalid_o = vld_q[RD_LATENCY-1];
  assign rdata_o  = data_q[RD_LATENCY-1];

  logic        putchar_valid_q;
  logic [7:0]  putchar_data_q;
  logic        exit_valid_q;
  logic [31:0] exit_code_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      putchar_valid_q <= 1'b0;
      putchar_data_q  <= 8'h0;
      exit_valid_q    <= 1'b0;
      exit_code_q     <= 32'h0;
    end else begin
      putchar_valid_q <= putchar_wr;
      if (putchar_wr) putchar_data_q <= wdata_i[7:0];
      if (tohost_wr) begin
        exit_valid_q <= 1'b1;
        exit_code_q  <= wdata_i;
      end
    end
  end

  assign putchar_valid_o = putchar_valid_q;
  assign putchar_data_o  = putchar_data_q;
  assign exit_valid_o    = exit_valid_q;
  assign exit_code_o     = exit_code_q;

  // Storage is deliberately outside the reset domain so preloaded images survive rst_i.
  always_ff @(posedge clk_i) begin
    if (mem_wr) begin
      for (int n = 0; n < 4; n++) begin
        if (be_i[n]) mem[widx][8*n +: 8] <= wdata_i[8*n +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/rv32imf_mem_responder.md
# rv32imf_mem_responder

Synthesizable responder for the rv32imf core's instruction or data port, implementing the req/gnt/rvalid protocol from the memory side. Holds a byte-enabled word memory and adds programmable grant wait states and read latency. It also decodes two MMIO words: a `tohost` exit register and a `putchar` stdout port. The block replaces the behavioural memory in benches and FPGA builds; one instance serves the instruction port and one serves the data port.

## Interface
- `MEM_AW`, 14: word-address width; memory holds 2**MEM_AW 32-bit words in array `mem`, preloadable by `$readmemh`.
- `RD_LATENCY`, 1: cycles from accept to `rvalid_o`; legal range 1..4.
- `GNT_WAIT`, 0: wait cycles between first sight of `req_i` and `gnt_o`; legal range 0..7.
- `TOHOST_ADDR`, 32'h0000_1000: byte address of the exit register.
- `PUTCHAR_ADDR`, 32'h0000_1004: byte address of the stdout port.

Ports:
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `req_i`  in  1  request valid.
- `addr_i`  in  32  byte address; bits [1:0] ignored.
- `we_i`  in  1  1 = write, 0 = read.
- `be_i`  in  4  byte enables; bit n enables lane [8n+7:8n].
- `wdata_i`  in  32  write data.
- `gnt_o`  out  1  grant; a request is accepted in a cycle with `req_i && gnt_o`.
- `rvalid_o`  out  1  response valid, one pulse per accepted request.
- `rdata_o`  out  32  read data; valid only with `rvalid_o`.
- `putchar_valid_o`  out  1  one-cycle pulse per accepted write to `PUTCHAR_ADDR`.
- `putchar_data_o`  out  8  character; holds its last value.
- `exit_valid_o`  out  1  sticky; set by a full-word write to `TOHOST_ADDR`.
- `exit_code_o`  out  32  captured exit code.

## Operation
- **Grant FSM, states IDLE and WAIT**
  - `GNT_WAIT`=0: `gnt_o` = `req_i`, combinational, forced 0 while `rst_i` is high.
  - `GNT_WAIT`>0, IDLE: `req_i` high moves the FSM to WAIT with `wcnt`=1 and `gnt_o`=0.
  - WAIT, `wcnt`<`GNT_WAIT`: increment `wcnt`.
  - WAIT, `wcnt`==`GNT_WAIT`: `gnt_o`=1 combinationally, return to IDLE, clear `wcnt`.
  - `req_i` dropping in WAIT returns the FSM to IDLE with no grant (protocol violation tolerated).
  - Every request pays the full wait, including back-to-back requests.
- **Memory access**
  - Word index = `addr_i[MEM_AW+1:2]`. Upper address bits alias, except the two MMIO addresses.
  - Write: each lane with `be_i[n]` set is written on the accept edge. Lanes with `be_i[n]`=0 are unchanged. `be_i`=0 is a no-op that still responds.
  - Read: the word is sampled on the accept edge. A read accepted the cycle after a write to the same word returns the new data.
- **Response pipeline**
  - A `RD_LATENCY`-deep shift register of {valid, data} with no backpressure.
  - Up to `RD_LATENCY` requests may be outstanding.
  - Responses return in order.
  - Writes also produce `rvalid_o`, with `rdata_o`=0.
- **MMIO decode** (full 32-bit address compare, `addr_i[1:0]` masked)
  - Write to `TOHOST_ADDR` with `be_i`=4'hF sets `exit_valid_o`=1 and `exit_code_o`=`wdata_i`. A later tohost write overwrites the code. Memory is not written.
  - A partial-`be_i` write to `TOHOST_ADDR` goes to memory.
  - Any write to `PUTCHAR_ADDR` pulses `putchar_valid_o` and loads `putchar_data_o`=`wdata_i[7:0]`. Memory is not written.
  - Reads of either MMIO address return 0.
- **Reset**
  - Pipeline is flushed and outstanding responses are dropped.
  - FSM goes to IDLE and `wcnt`=0.
  - Outputs: `gnt_o`=0, `rvalid_o`=0, `rdata_o`=0, `putchar_valid_o`=0, `putchar_data_o`=0, `exit_valid_o`=0, `exit_code_o`=0.
  - Memory contents are not cleared.

## Timing
- A request first presented in cycle t is granted in cycle t+`GNT_WAIT`.
- A request accepted in cycle a produces `rvalid_o` in cycle a+`RD_LATENCY`.
- Sustained throughput is 1 request/cycle when `GNT_WAIT`=0, and 1 per `GNT_WAIT`+1 cycles otherwise.
- `putchar_valid_o` is high in cycle a+1.
- `exit_valid_o` rises in cycle a+1.
- Reset takes effect without a clock edge. The first grant (`GNT_WAIT`=0) is possible in the first cycle after `rst_i` deasserts.

## Test plan
- **Back-to-back read/write, `RD_LATENCY`=1, `GNT_WAIT`=0**
  - Stimulus: write 0xDEADBEEF to 0x40, then read 0x40 in the next cycle.
  - Required: `gnt_o` high both cycles, `rvalid_o` in cycles a+1 and a+2, read returns 0xDEADBEEF.
- **Byte enables**
  - Stimulus: preload 0x11223344 at 0x80, write 0xAABBCCDD with `be_i`=4'b0101, then read 0x80.
  - Required: read returns 0x11BB33DD.
- **Wait states and latency, `GNT_WAIT`=3, `RD_LATENCY`=2**
  - Stimulus: `req_i` held high from cycle 10 for three requests.
  - Required: grants in cycles 13, 17 and 21; `rvalid_o` in cycles 15, 19 and 23.
- **MMIO**
  - Stimulus: write 'H', 'i', '\n' to `PUTCHAR_ADDR`, then 0x0 to `TOHOST_ADDR` with `be_i`=F.
  - Required: three `putchar_valid_o` pulses with data 0x48, 0x69, 0x0A; `exit_valid_o`=1, `exit_code_o`=0; the memory word at the tohost index is unchanged.
- **Reset mid-operation, `RD_LATENCY`=3**
  - Stimulus: accept two reads, assert `rst_i` one cycle later for 2 cycles.
  - Required: no `rvalid_o` ever appears for those reads; all outputs are 0 during and after reset; a preloaded word still reads back correctly after reset.
